// File: rtl/branch_ctrl.sv
// Branch resolution controller for the EX stage: resolves taken/not-taken, detects
// mispredicts, runs the redirect handshake and timed flush, and keeps statistics.
module branch_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             br_valid_i,
    input  logic             br_jump_i,
    input  logic [2:0]       br_funct3_i,
    input  logic             br_pred_taken_i,
    input  logic [XLEN-1:0]  br_pc_i,
    input  logic [XLEN-1:0]  br_target_i,
    input  logic             br_equal_i,
    input  logic             br_less_i,
    output logic             br_unsigned_o,
    output logic             redirect_valid_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    input  logic             redirect_ready_i,
    output logic             stall_o,
    output logic             flush_o,
    input  logic             cnt_clr_i,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        REDIRECT = 2'b01,
        FLUSH    = 2'b10
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [3:0]        flush_cnt_r;
    logic [3:0]        flush_cnt_next_s;
    logic              taken_s;
    logic              legal_s;
    logic              accepted_s;
    logic              mispredict_s;
    logic [XLEN-1:0]   correct_pc_s;
    logic              redirect_valid_r;
    logic              stall_r;
    logic              flush_r;
    logic [XLEN-1:0]   redirect_pc_r;
    logic [CNT_W-1:0]  branch_cnt_r;
    logic [CNT_W-1:0]  mispred_cnt_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // The comparator is combinational, so the signedness select follows funct3 directly.
    assign br_unsigned_o = br_funct3_i[1];

    // Branch outcome decode; funct3 010/011 are not branches and are never accepted.
    always_comb begin
        legal_s = 1'b1;
        taken_s = 1'b0;
        if (br_jump_i) begin
            taken_s = 1'b1;
        end else begin
            case (br_funct3_i)
                3'b000:  taken_s = br_equal_i;
                3'b001:  taken_s = !br_equal_i;
                3'b100:  taken_s = br_less_i;
                3'b101:  taken_s = !br_less_i;
                3'b110:  taken_s = br_less_i;
                3'b111:  taken_s = !br_less_i;
                default: legal_s = 1'b0;
            endcase
        end
    end

    assign accepted_s   = br_valid_i && (state_r == IDLE) && legal_s;
    assign mispredict_s = accepted_s && (taken_s != br_pred_taken_i);
    assign correct_pc_s = taken_s ? br_target_i : br_pc_i + XLEN'(4);

    // Next-state logic for the redirect/flush sequencer.
    always_comb begin
        state_next_s     = state_r;
        flush_cnt_next_s = flush_cnt_r;
        case (state_r)
            IDLE: begin
                if (mispredict_s) state_next_s = REDIRECT;
                else              state_next_s = IDLE;
            end
            REDIRECT: begin
                if (redirect_ready_i) begin
                    if (FLUSH_CYCLES == 32'sd0) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s     = FLUSH;
                        flush_cnt_next_s = 4'(FLUSH_CYCLES);
                    end
                end else begin
                    state_next_s = REDIRECT;
                end
            end
            FLUSH: begin
                if (flush_cnt_r <= 4'd1) begin
                    state_next_s     = IDLE;
                    flush_cnt_next_s = 4'd0;
                end else begin
                    state_next_s     = FLUSH;
                    flush_cnt_next_s = flush_cnt_r - 4'd1;
                end
            end
            default: begin
                state_next_s     = IDLE;
                flush_cnt_next_s = 4'd0;
            end
        endcase
    end

    // State register with outputs registered from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r          <= IDLE;
            flush_cnt_r      <= 4'd0;
            redirect_valid_r <= 1'b0;
            stall_r          <= 1'b0;
            flush_r          <= 1'b0;
            redirect_pc_r    <= '0;
        end else begin
            state_r          <= state_next_s;
            flush_cnt_r      <= flush_cnt_next_s;
            redirect_valid_r <= (state_next_s == REDIRECT);
            stall_r          <= (state_next_s == REDIRECT);
            flush_r          <= (state_next_s == FLUSH);
            if (mispredict_s) redirect_pc_r <= correct_pc_s;
        end
    end

    // Saturating statistics; a clear overrides any same-cycle increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            branch_cnt_r  <= '0;
            mispred_cnt_r <= '0;
        end else if (cnt_clr_i) begin
            branch_cnt_r  <= '0;
            mispred_cnt_r <= '0;
        end else begin
            if (accepted_s)   branch_cnt_r  <= sat_inc(branch_cnt_r);
            if (mispredict_s) mispred_cnt_r <= sat_inc(mispred_cnt_r);
        end
    end

    assign redirect_valid_o = redirect_valid_r;
    assign redirect_pc_o    = redirect_pc_r;
    assign stall_o          = stall_r;
    assign flush_o          = flush_r;
    assign branch_cnt_o     = branch_cnt_r;
    assign mispred_cnt_o    = mispred_cnt_r;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl; counters built 8 bits wide so saturation is reachable.
module tb_branch_ctrl;

    localparam int XLEN  = 32;
    localparam int CNT_W = 8;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             br_valid_i;
    logic             br_jump_i;
    logic [2:0]       br_funct3_i;
    logic             br_pred_taken_i;
    logic [XLEN-1:0]  br_pc_i;
    logic [XLEN-1:0]  br_target_i;
    logic             br_equal_i;
    logic             br_less_i;
    logic             br_unsigned_o;
    logic             redirect_valid_o;
    logic [XLEN-1:0]  redirect_pc_o;
    logic             redirect_ready_i;
    logic             stall_o;
    logic             flush_o;
    logic             cnt_clr_i;
    logic [CNT_W-1:0] branch_cnt_o;
    logic [CNT_W-1:0] mispred_cnt_o;

    int total = 0;
    int bad   = 0;

    branch_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .br_valid_i(br_valid_i), .br_jump_i(br_jump_i),
        .br_funct3_i(br_funct3_i), .br_pred_taken_i(br_pred_taken_i), .br_pc_i(br_pc_i),
        .br_target_i(br_target_i), .br_equal_i(br_equal_i), .br_less_i(br_less_i),
        .br_unsigned_o(br_unsigned_o), .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o(redirect_pc_o), .redirect_ready_i(redirect_ready_i),
        .stall_o(stall_o), .flush_o(flush_o), .cnt_clr_i(cnt_clr_i),
        .branch_cnt_o(branch_cnt_o), .mispred_cnt_o(mispred_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_br(input logic v, input logic [2:0] f3, input logic pred,
                          input logic [31:0] pc, input logic [31:0] tgt,
                          input logic eq, input logic lt);
        br_valid_i = v; br_jump_i = 1'b0; br_funct3_i = f3; br_pred_taken_i = pred;
        br_pc_i = pc; br_target_i = tgt; br_equal_i = eq; br_less_i = lt;
    endtask

    // Mispredicting BEQ, immediate accept, then drain the 2-cycle flush back to IDLE.
    task automatic mispredict_round();
        set_br(1'b1, 3'b000, 1'b1, 32'h40, 32'h80, 1'b0, 1'b0);
        step();
        br_valid_i = 1'b0; redirect_ready_i = 1'b1;
        step();
        redirect_ready_i = 1'b0;
        step();
        step();
    endtask

    initial begin
        rst_ni = 1'b0; redirect_ready_i = 1'b0; cnt_clr_i = 1'b0;
        set_br(1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #12;
        check("rst_redirect_valid", 32'(redirect_valid_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_flush", 32'(flush_o), 32'd0);
        check("rst_pc", redirect_pc_o, 32'h0);
        check("rst_bcnt", 32'(branch_cnt_o), 32'd0);
        check("rst_mcnt", 32'(mispred_cnt_o), 32'd0);
        step();
        rst_ni = 1'b1;
        step();

        // BEQ correctly predicted taken
        set_br(1'b1, 3'b000, 1'b1, 32'h10, 32'h20, 1'b1, 1'b0);
        #1;
        check("beq_unsigned", 32'(br_unsigned_o), 32'd0);
        step();
        br_valid_i = 1'b0;
        check("beq_no_redirect", 32'(redirect_valid_o), 32'd0);
        check("beq_bcnt", 32'(branch_cnt_o), 32'd1);
        check("beq_mcnt", 32'(mispred_cnt_o), 32'd0);

        // BLTU mispredicted, redirect held while ready stays low
        set_br(1'b1, 3'b110, 1'b0, 32'h100, 32'h80, 1'b0, 1'b1);
        #1;
        check("bltu_unsigned", 32'(br_unsigned_o), 32'd1);
        step();
        br_valid_i = 1'b0;
        check("bltu_valid", 32'(redirect_valid_o), 32'd1);
        check("bltu_pc", redirect_pc_o, 32'h80);
        check("bltu_mcnt", 32'(mispred_cnt_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bltu_hold_valid", 32'(redirect_valid_o), 32'd1);
            check("bltu_hold_pc", redirect_pc_o, 32'h80);
            check("bltu_hold_stall", 32'(stall_o), 32'd1);
        end
        redirect_ready_i = 1'b1;
        step();
        redirect_ready_i = 1'b0;
        check("bltu_flush1", 32'(flush_o), 32'd1);
        check("bltu_flush_stall", 32'(stall_o), 32'd0);
        step();
        check("bltu_flush2", 32'(flush_o), 32'd1);
        step();
        check("bltu_flush_end", 32'(flush_o), 32'd0);

        // BNE not taken vs predicted taken; wrong-path branches during REDIRECT and FLUSH
        set_br(1'b1, 3'b001, 1'b1, 32'h200, 32'h300, 1'b1, 1'b0);
        step();
        check("bne_pc", redirect_pc_o, 32'h204);
        check("bne_bcnt", 32'(branch_cnt_o), 32'd3);
        redirect_ready_i = 1'b1;
        step();
        redirect_ready_i = 1'b0;
        check("bne_flush1", 32'(flush_o), 32'd1);
        step();
        check("bne_flush2", 32'(flush_o), 32'd1);
        br_valid_i = 1'b0;
        step();
        check("bne_flush_end", 32'(flush_o), 32'd0);
        check("bne_idle_valid", 32'(redirect_valid_o), 32'd0);
        check("wrongpath_bcnt", 32'(branch_cnt_o), 32'd3);
        check("wrongpath_mcnt", 32'(mispred_cnt_o), 32'd2);

        // BGE not taken from the top of memory: fall-through wraps to zero
        set_br(1'b1, 3'b101, 1'b1, 32'hFFFF_FFFC, 32'h1000, 1'b0, 1'b1);
        step();
        br_valid_i = 1'b0;
        check("bge_wrap_pc", redirect_pc_o, 32'h0);
        redirect_ready_i = 1'b1;
        step();
        redirect_ready_i = 1'b0;
        step();
        step();

        // Illegal funct3 is ignored
        set_br(1'b1, 3'b010, 1'b1, 32'h500, 32'h600, 1'b0, 1'b0);
        step();
        br_valid_i = 1'b0;
        check("illegal_no_redirect", 32'(redirect_valid_o), 32'd0);
        check("illegal_bcnt", 32'(branch_cnt_o), 32'd4);
        check("illegal_mcnt", 32'(mispred_cnt_o), 32'd3);

        // Drive mispredicts to saturation and one beyond
        for (int i = 0; i < 253; i++) mispredict_round();
        check("sat_mcnt", 32'(mispred_cnt_o), 32'hFF);
        check("sat_bcnt", 32'(branch_cnt_o), 32'hFF);

        // Clear wins over a same-cycle increment
        set_br(1'b1, 3'b000, 1'b1, 32'h40, 32'h80, 1'b1, 1'b0);
        cnt_clr_i = 1'b1;
        step();
        cnt_clr_i = 1'b0;
        br_valid_i = 1'b0;
        check("clr_bcnt", 32'(branch_cnt_o), 32'd0);
        check("clr_mcnt", 32'(mispred_cnt_o), 32'd0);

        // Async reset while a redirect is pending
        set_br(1'b1, 3'b000, 1'b1, 32'h40, 32'h80, 1'b0, 1'b0);
        step();
        br_valid_i = 1'b0;
        check("pre_rst_valid", 32'(redirect_valid_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_rst_valid", 32'(redirect_valid_o), 32'd0);
        check("async_rst_stall", 32'(stall_o), 32'd0);
        step();
        rst_ni = 1'b1;
        step();
        check("post_rst_valid", 32'(redirect_valid_o), 32'd0);
        set_br(1'b1, 3'b000, 1'b1, 32'h40, 32'h80, 1'b1, 1'b0);
        step();
        br_valid_i = 1'b0;
        check("post_rst_idle_bcnt", 32'(branch_cnt_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
